chip_gate_tester: RTL and testbench

CHIP_GATE_TESTER -- requirements
Module: chip_gate_tester

---
 rtl/chip_test_pkg.sv | 45 ++++
 rtl/pin_sync.sv | 25 ++
 rtl/chip_gate_tester.sv | 147 ++++++++++++++
 tb/tb_chip_gate_tester.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/chip_test_pkg.sv
// Shared definitions for the logic-gate chip tester: device encoding,
// gate-count table and the ideal-gate expected-output function.
package chip_test_pkg;

   typedef enum logic [1:0] {
      CHIP_NOT = 2'd0,
      CHIP_AND = 2'd1,
      CHIP_OR  = 2'd2,
      CHIP_XOR = 2'd3
   } chip_t;

   localparam int PINS = 6;
   localparam logic [2:0] GATES_HEX  = 3'd6;
   localparam logic [2:0] GATES_QUAD = 3'd4;

   function automatic logic [2:0] gate_count(input chip_t chip);
      return (chip == CHIP_NOT) ? GATES_HEX : GATES_QUAD;
   endfunction

   function automatic logic [PINS-1:0] used_mask(input chip_t chip);
      return (chip == CHIP_NOT) ? 6'b11_1111 : 6'b00_1111;
   endfunction

   function automatic logic [PINS-1:0] expected_y(input chip_t chip,
                                                  input logic [PINS-1:0] a,
                                                  input logic [PINS-1:0] b);
      logic [PINS-1:0] y;
      unique case (chip)
         CHIP_NOT: y = ~a;
         CHIP_AND: y = a & b;
         CHIP_OR:  y = a | b;
         default:  y = a ^ b;
      endcase
      return y & used_mask(chip);
   endfunction

   function automatic logic [2:0] lowest_set(input logic [PINS-1:0] x);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = PINS - 1; i >= 0; i--)
         if (x[i]) idx = 3'(i);
      return idx;
   endfunction

endpackage

// File: rtl/pin_sync.sv
// Two-flop synchronizer bringing the socket outputs into the clk domain.
module pin_sync
   import chip_test_pkg::*;
#(
   parameter int WIDTH = PINS
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_p0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_p0 <= '0;
         q       <= '0;
      end else begin
         meta_p0 <= d;
         q       <= meta_p0;
      end
   end

endmodule

// File: rtl/chip_gate_tester.sv
// Functional tester for 74x04/08/32/86 parts: walks every gate through every
// input vector, neighbours driven inverted, and reports the first bad gate.
module chip_gate_tester
   import chip_test_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [1:0] chip_sel,
   output logic [5:0] pin_a,
   output logic [5:0] pin_b,
   input  logic [5:0] pin_y,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] fail_gate,
   output logic [1:0] fail_vec
);

   typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_t;

   state_t     state_q, state_d;
   chip_t      chip_q, chip_d;
   logic [2:0] g_q, g_d;
   logic [1:0] v_q, v_d;
   logic [7:0] cnt_q, cnt_d;
   logic [5:0] pin_a_d, pin_b_d;
   logic       pass_d;
   logic [2:0] fail_gate_d;
   logic [1:0] fail_vec_d;

   logic [5:0] y_sync, mask, sel, step_a, step_b, mism;
   logic       a_bit, b_bit, last_v, last_g;

   pin_sync #(.WIDTH(PINS)) u_pin_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pin_y),
      .q     (y_sync)
   );

   // Current step's socket drive: gate g gets v, the other used gates get ~v.
   always_comb begin
      mask   = used_mask(chip_q);
      sel    = 6'b00_0001 << g_q;
      a_bit  = (chip_q == CHIP_NOT) ? v_q[0] : v_q[1];
      b_bit  = v_q[0];
      step_a = (({6{a_bit}} & sel) | ({6{~a_bit}} & ~sel)) & mask;
      step_b = (chip_q == CHIP_NOT) ? 6'b0
             : ((({6{b_bit}} & sel) | ({6{~b_bit}} & ~sel)) & mask);
      mism   = (y_sync ^ expected_y(chip_q, pin_a, pin_b)) & mask;
      last_v = (chip_q == CHIP_NOT) ? (v_q == 2'd1) : (v_q == 2'd3);
      last_g = (g_q == gate_count(chip_q) - 3'd1);
   end

   always_comb begin
      state_d     = state_q;
      chip_d      = chip_q;
      g_d         = g_q;
      v_d         = v_q;
      cnt_d       = cnt_q;
      pin_a_d     = pin_a;
      pin_b_d     = pin_b;
      pass_d      = pass;
      fail_gate_d = fail_gate;
      fail_vec_d  = fail_vec;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               chip_d      = chip_t'(chip_sel);
               g_d         = 3'd0;
               v_d         = 2'd0;
               pass_d      = 1'b0;
               fail_gate_d = 3'd0;
               fail_vec_d  = 2'd0;
               state_d     = DRIVE;
            end
         end
         DRIVE: begin
            pin_a_d = step_a;
            pin_b_d = step_b;
            cnt_d   = 8'd0;
            state_d = SETTLE;
         end
         SETTLE: begin
            if (cnt_q == 8'(SETTLE_CYCLES - 1)) state_d = CHECK;
            else                                cnt_d   = cnt_q + 8'd1;
         end
         CHECK: begin
            if (|mism) begin
               fail_gate_d = lowest_set(mism);
               fail_vec_d  = v_q;
               pass_d      = 1'b0;
               pin_a_d     = 6'b0;
               pin_b_d     = 6'b0;
               state_d     = DONE;
            end else if (last_v && last_g) begin
               pass_d  = 1'b1;
               pin_a_d = 6'b0;
               pin_b_d = 6'b0;
               state_d = DONE;
            end else begin
               if (last_v) begin
                  v_d = 2'd0;
                  g_d = g_q + 3'd1;
               end else begin
                  v_d = v_q + 2'd1;
               end
               state_d = DRIVE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         chip_q    <= CHIP_NOT;
         g_q       <= 3'd0;
         v_q       <= 2'd0;
         cnt_q     <= 8'd0;
         pin_a     <= 6'b0;
         pin_b     <= 6'b0;
         pass      <= 1'b0;
         fail_gate <= 3'd0;
         fail_vec  <= 2'd0;
      end else begin
         state_q   <= state_d;
         chip_q    <= chip_d;
         g_q       <= g_d;
         v_q       <= v_d;
         cnt_q     <= cnt_d;
         pin_a     <= pin_a_d;
         pin_b     <= pin_b_d;
         pass      <= pass_d;
         fail_gate <= fail_gate_d;
         fail_vec  <= fail_vec_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);

endmodule

// File: tb/tb_chip_gate_tester.sv
// Bench for chip_gate_tester: behavioural socket with injectable faults and a
// step-walking reference model of the expected verdict and timing.
module tb_chip_gate_tester;

   localparam int S = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [1:0] chip_sel = 2'd0;
   logic [5:0] pin_a, pin_b, pin_y;
   logic       busy, done, pass;
   logic [2:0] fail_gate;
   logic [1:0] fail_vec;

   int tests = 0;
   int fails = 0;

   logic [1:0] sock_chip = 2'd1;
   logic [5:0] sa0 = 6'b0, sa1 = 6'b0, shorted = 6'b0;

   chip_gate_tester #(.SETTLE_CYCLES(S)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .chip_sel  (chip_sel),
      .pin_a     (pin_a),
      .pin_b     (pin_b),
      .pin_y     (pin_y),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .fail_gate (fail_gate),
      .fail_vec  (fail_vec)
   );

   always #5 clk = ~clk;

   function automatic logic gate_ref(input logic [1:0] t, input logic a, input logic b);
      case (t)
         2'd0:    return ~a;
         2'd1:    return a & b;
         2'd2:    return a | b;
         default: return a ^ b;
      endcase
   endfunction

   // Device in the socket: quad parts leave pins 5:4 floating high.
   function automatic logic [5:0] socket(input logic [1:0] t, input logic [5:0] a,
                                         input logic [5:0] b, input logic [5:0] s0,
                                         input logic [5:0] s1, input logic [5:0] sh);
      logic [5:0] y;
      logic       w;
      for (int i = 0; i < 6; i++) y[i] = (t != 2'd0 && i >= 4) ? 1'b1 : gate_ref(t, a[i], b[i]);
      w = 1'b1;
      for (int i = 0; i < 6; i++) if (sh[i]) w = w & y[i];
      for (int i = 0; i < 6; i++) if (sh[i]) y[i] = w;
      return (y & ~s0) | s1;
   endfunction

   assign pin_y = socket(sock_chip, pin_a, pin_b, sa0, sa1, shorted);

   function automatic logic [11:0] step_vec(input logic [1:0] t, input int g, input int v);
      logic [5:0] a, b;
      logic       av, bv;
      int         n;
      n  = (t == 2'd0) ? 6 : 4;
      av = (t == 2'd0) ? v[0] : v[1];
      bv = v[0];
      a  = 6'b0;
      b  = 6'b0;
      for (int i = 0; i < n; i++) begin
         a[i] = (i == g) ? av : ~av;
         b[i] = (t == 2'd0) ? 1'b0 : ((i == g) ? bv : ~bv);
      end
      return {a, b};
   endfunction

   task automatic model(input logic [1:0] sel, output logic e_pass, output logic [2:0] e_gate,
                        output logic [1:0] e_vec, output int e_lat);
      int         n_g, n_v, steps;
      logic [11:0] ab;
      logic [5:0] y;
      bit         found;
      n_g = (sel == 2'd0) ? 6 : 4;
      n_v = (sel == 2'd0) ? 2 : 4;
      found = 1'b0;
      steps = 0;
      e_gate = 3'd0;
      e_vec = 2'd0;
      for (int g = 0; g < n_g; g++)
         for (int v = 0; v < n_v; v++)
            if (!found) begin
               steps++;
               ab = step_vec(sel, g, v);
               y  = socket(sock_chip, ab[11:6], ab[5:0], sa0, sa1, shorted);
               for (int i = n_g - 1; i >= 0; i--)
                  if (y[i] !== gate_ref(sel, ab[6+i], ab[i])) begin
                     found  = 1'b1;
                     e_gate = 3'(i);
                     e_vec  = 2'(v);
                  end
            end
      e_pass = !found;
      e_lat  = steps * (S + 2) + 1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_pin_a"}, 32'(pin_a), 32'd0);
      check({tag, "_pin_b"}, 32'(pin_b), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_pass"}, 32'(pass), 32'd0);
      check({tag, "_fgate"}, 32'(fail_gate), 32'd0);
      check({tag, "_fvec"}, 32'(fail_vec), 32'd0);
   endtask

   task automatic run_test(input string tag, input logic [1:0] sel, input bit hold_start,
                           input bit toggle_sel);
      logic        e_pass;
      logic [2:0]  e_gate;
      logic [1:0]  e_vec;
      int          e_lat, cycles, done_cnt;
      logic [11:0] ab0;
      bit          seen;
      model(sel, e_pass, e_gate, e_vec, e_lat);
      ab0 = step_vec(sel, 0, 0);
      chip_sel = sel;
      start = 1'b1;
      cycles = 0;
      done_cnt = 0;
      seen = 1'b0;
      while (!seen && cycles < 400) begin
         @(posedge clk);
         #1;
         cycles++;
         if (!hold_start) start = 1'b0;
         if (toggle_sel) chip_sel = 2'($urandom);
         if (cycles == 1) check({tag, "_busy"}, 32'(busy), 32'd1);
         if (cycles == 2) begin
            check({tag, "_step0_a"}, 32'(pin_a), 32'(ab0[11:6]));
            check({tag, "_step0_b"}, 32'(pin_b), 32'(ab0[5:0]));
         end
         if (done) begin
            seen = 1'b1;
            done_cnt++;
         end
      end
      check({tag, "_done_seen"}, 32'(seen), 32'd1);
      check({tag, "_latency"}, 32'(cycles), 32'(e_lat));
      check({tag, "_pass"}, 32'(pass), 32'(e_pass));
      check({tag, "_fail_gate"}, 32'(fail_gate), 32'(e_gate));
      check({tag, "_fail_vec"}, 32'(fail_vec), 32'(e_vec));
      check({tag, "_pins_off"}, 32'({pin_a, pin_b}), 32'd0);
      @(posedge clk);
      #1;
      if (done) done_cnt++;
      start = 1'b0;
      check({tag, "_done_once"}, 32'(done_cnt), 32'd1);
      check({tag, "_busy_end"}, 32'(busy), 32'd0);
      check({tag, "_pass_held"}, 32'(pass), 32'(e_pass));
   endtask

   task automatic set_socket(input logic [1:0] t, input logic [5:0] s0, input logic [5:0] s1,
                             input logic [5:0] sh);
      sock_chip = t;
      sa0 = s0;
      sa1 = s1;
      shorted = sh;
   endtask

   initial begin
      int cycles;
      logic [1:0] sel;
      int k;

      #12;
      check_idle_outputs("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      set_socket(2'd1, 6'b0, 6'b0, 6'b0);
      run_test("and_ideal", 2'd1, 1'b0, 1'b0);

      set_socket(2'd0, 6'b10_0000, 6'b0, 6'b0);
      run_test("not_sa0_g5", 2'd0, 1'b0, 1'b0);

      set_socket(2'd3, 6'b0, 6'b0, 6'b00_0110);
      run_test("xor_short12", 2'd3, 1'b0, 1'b0);

      set_socket(2'd1, 6'b0, 6'b0, 6'b00_0110);
      run_test("and_short12", 2'd1, 1'b0, 1'b0);

      set_socket(2'd2, 6'b0, 6'b0, 6'b0);
      run_test("or_as_and", 2'd1, 1'b0, 1'b0);

      // Reset in the middle of step 7's settle window.
      set_socket(2'd1, 6'b0, 6'b0, 6'b0);
      chip_sel = 2'd1;
      start = 1'b1;
      cycles = 0;
      while (cycles < 45) begin
         @(posedge clk);
         #1;
         cycles++;
         start = 1'b0;
      end
      check("mid_busy", 32'(busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_idle_outputs("mid_rst");
      @(posedge clk);
      #1;
      check_idle_outputs("mid_rst_edge");
      rst_n = 1'b1;
      run_test("after_rst", 2'd1, 1'b0, 1'b0);

      set_socket(2'd3, 6'b0, 6'b0, 6'b0);
      run_test("hold_toggle_xor", 2'd3, 1'b1, 1'b1);
      set_socket(2'd0, 6'b0, 6'b0, 6'b0);
      run_test("hold_toggle_not", 2'd0, 1'b1, 1'b1);

      for (int n = 0; n < 12; n++) begin
         sel = 2'($urandom);
         set_socket(($urandom_range(0, 2) == 0) ? 2'($urandom) : sel, 6'b0, 6'b0, 6'b0);
         k = $urandom_range(0, 5);
         case ($urandom_range(0, 3))
            1:       sa0 = 6'b1 << k;
            2:       sa1 = 6'b1 << k;
            3:       shorted = 6'b11 << $urandom_range(0, 4);
            default: ;
         endcase
         run_test($sformatf("rand%0d", n), sel, 1'b0, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
